// File: rtl/aes_pkg.sv
// Shared AES types and arithmetic: FSM state enum, round-count helper,
// forward/inverse S-box tables and GF(2^8) multiply helpers.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte i of the table sits at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nr_of(input int key_bits);
    case (key_bits)
      128:     return 10;
      192:     return 12;
      256:     return 14;
      default: return 0;
    endcase
  endfunction

  // Inverse table derived from SBOX at elaboration so the two cannot disagree.
  function automatic logic [2047:0] build_inv_sbox();
    logic [2047:0] t;
    logic [7:0]    v;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      v = SBOX[2047 - 8*i -: 8];
      t[2047 - 8*int'(v) -: 8] = 8'(i);
    end
    return t;
  endfunction

  localparam logic [2047:0] INV_SBOX = build_inv_sbox();

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Block-in / block-out handshake bundle for aes_iter_core.
interface aes_iter_core_if;
  import aes_pkg::*;

  // A transfer happens on a rising edge where valid && ready; the source holds
  // data stable while valid && !ready and never waits on ready to raise valid.
  logic   in_valid;
  logic   in_ready;
  block_t in_data;
  logic   in_decr;
  logic   out_valid;
  logic   out_ready;
  block_t out_data;
  logic   out_decr;

  modport core (
    input  in_valid, in_data, in_decr, out_ready,
    output in_ready, out_valid, out_data, out_decr
  );

  modport master (
    output in_valid, in_data, in_decr, out_ready,
    input  in_ready, out_valid, out_data, out_decr
  );

endinterface

// File: rtl/aes_round_fn.sv
// Combinational single AES round, forward or inverse; 'first' is the bare
// initial AddRoundKey, 'last' drops the (Inv)MixColumns step.
module aes_round_fn
  import aes_pkg::*;
(
  input  block_t state_in,
  input  block_t key,
  input  logic   decr,
  input  logic   first,
  input  logic   last,
  output block_t state_out
);

  block_t sh_e;
  block_t sh_d;
  block_t sb_e;
  block_t sb_d;
  block_t ak_d;
  block_t mx_e;
  block_t mx_d;

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic [7:0] k0,
                                          input logic [7:0] k1, input logic [7:0] k2,
                                          input logic [7:0] k3);
    logic [3:0][7:0] s;
    logic [31:0]     o;
    o = '0;
    for (int r = 0; r < 4; r++) s[r] = col[31 - 8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      o[31 - 8*r -: 8] = gf_mul(k0, s[r]) ^ gf_mul(k1, s[(r + 1) % 4]) ^
                         gf_mul(k2, s[(r + 2) % 4]) ^ gf_mul(k3, s[(r + 3) % 4]);
    end
    return o;
  endfunction

  // Byte (row r, column c) of a block lives at bits [127-8*(r+4c) -: 8].
  always_comb begin
    sh_e      = '0;
    sh_d      = '0;
    sb_e      = '0;
    sb_d      = '0;
    ak_d      = '0;
    mx_e      = '0;
    mx_d      = '0;
    state_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sh_e[127 - 8*(r + 4*c) -: 8] = state_in[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        sh_d[127 - 8*(r + 4*c) -: 8] = state_in[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    for (int k = 0; k < 16; k++) begin
      sb_e[127 - 8*k -: 8] = sbox(sh_e[127 - 8*k -: 8]);
      sb_d[127 - 8*k -: 8] = inv_sbox(sh_d[127 - 8*k -: 8]);
    end
    ak_d = sb_d ^ key;
    for (int c = 0; c < 4; c++) begin
      mx_e[127 - 32*c -: 32] = mix_col(sb_e[127 - 32*c -: 32], 8'h02, 8'h03, 8'h01, 8'h01);
      mx_d[127 - 32*c -: 32] = mix_col(ak_d[127 - 32*c -: 32], 8'h0e, 8'h0b, 8'h0d, 8'h09);
    end
    if (first)     state_out = state_in ^ key;
    else if (decr) state_out = last ? ak_d : mx_d;
    else           state_out = last ? (sb_e ^ key) : (mx_e ^ key);
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 core, one round per clock, round keys read from
// external key memory. Define AES_ITER_CORE_ABORT_EN to add the abort input.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter int KADDR_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  aes_iter_core_if.core      bus,
  output logic [KADDR_W-1:0] key_addr,
  input  block_t             roundkey,
  output logic               busy,
`ifdef AES_ITER_CORE_ABORT_EN
  input  logic               abort,
`endif
  output state_t             dbg_state
);

  localparam int NR = nr_of(KEY_BITS);
  localparam logic [KADDR_W-1:0] NR_ADDR = KADDR_W'(NR);
  localparam logic [3:0]         NR_RND  = 4'(NR);

  generate
    if (NR == 0 || (2**KADDR_W) <= NR) begin : g_bad_cfg
      $error("aes_iter_core: KEY_BITS must be 128/192/256 and 2**KADDR_W > NR");
    end
  endgenerate

  state_t             state_q;
  logic [3:0]         rnd;
  block_t             blk;
  logic               decr_q;
  logic [KADDR_W-1:0] addr_q;
  logic               in_ready_q;
  logic               out_valid_q;
  block_t             out_data_q;
  logic               out_decr_q;
  logic               busy_q;
  block_t             round_out;
  logic [KADDR_W-1:0] addr_step;

  aes_round_fn u_round (
    .state_in  (blk),
    .key       (roundkey),
    .decr      (decr_q),
    .first     (rnd == 4'd0),
    .last      (rnd == NR_RND),
    .state_out (round_out)
  );

  // Decrypt walks the key schedule backwards; wrap past the ends is harmless.
  assign addr_step = decr_q ? (addr_q - KADDR_W'(1)) : (addr_q + KADDR_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rnd         <= '0;
      blk         <= '0;
      decr_q      <= 1'b0;
      addr_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_decr_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
`ifdef AES_ITER_CORE_ABORT_EN
      if (abort && state_q != IDLE) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        addr_q      <= '0;
        in_ready_q  <= 1'b1;
        busy_q      <= 1'b0;
      end else
`endif
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            blk        <= bus.in_data;
            decr_q     <= bus.in_decr;
            addr_q     <= bus.in_decr ? NR_ADDR : '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= PRIME;
          end
        end
        PRIME: begin
          addr_q  <= addr_step;
          rnd     <= '0;
          state_q <= ROUND;
        end
        ROUND: begin
          blk    <= round_out;
          addr_q <= addr_step;
          rnd    <= rnd + 4'd1;
          if (rnd == NR_RND) begin
            out_data_q  <= round_out;
            out_decr_q  <= decr_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_decr  = out_decr_q;
  assign key_addr      = addr_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors on 128/192/256 builds,
// key_addr sequencing, latency, backpressure and mid-block reset.
module tb_aes_iter_core;
  import aes_pkg::*;

  typedef logic [15:0][127:0] rk_set_t;

  localparam block_t PT     = 128'h00112233445566778899aabbccddeeff;
  localparam block_t CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam block_t CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam block_t CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_ALL = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int total = 0;
  int bad   = 0;

  aes_iter_core_if bus128 ();
  aes_iter_core_if bus192 ();
  aes_iter_core_if bus256 ();

  logic [3:0] ka128, ka192, ka256;
  block_t     rk128, rk192, rk256;
  logic       busy128, busy192, busy256;
  state_t     st128, st192, st256;
  block_t     mem128 [16];
  block_t     mem192 [16];
  block_t     mem256 [16];
`ifdef AES_ITER_CORE_ABORT_EN
  logic abort;
`endif

  aes_iter_core #(.KEY_BITS(128), .KADDR_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus128), .key_addr(ka128), .roundkey(rk128), .busy(busy128),
`ifdef AES_ITER_CORE_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(st128)
  );

  aes_iter_core #(.KEY_BITS(192), .KADDR_W(4)) dut192 (
    .clk(clk), .reset(reset), .bus(bus192), .key_addr(ka192), .roundkey(rk192), .busy(busy192),
`ifdef AES_ITER_CORE_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(st192)
  );

  aes_iter_core #(.KEY_BITS(256), .KADDR_W(4)) dut256 (
    .clk(clk), .reset(reset), .bus(bus256), .key_addr(ka256), .roundkey(rk256), .busy(busy256),
`ifdef AES_ITER_CORE_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(st256)
  );

  // synchronous key memories: data valid one cycle after the address
  always @(posedge clk) begin
    rk128 <= mem128[ka128];
    rk192 <= mem192[ka192];
    rk256 <= mem256[ka256];
  end

  // FIPS-197 key expansion; key is left-aligned, nk = 4/6/8 words
  function automatic rk_set_t expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_set_t     res;
    int          nr;
    nr  = nk + 6;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
      end
      w[i] = t ^ w[i-nk];
    end
    for (int r = 0; r <= nr; r++) res[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  // driver: offer one block to the 128-bit core and follow it to out_valid
  int               lat;
  block_t           res;
  logic             rdecr;
  logic [10:0][3:0] ka;

  task automatic run128(input block_t d, input logic decr);
    bus128.in_data  = d;
    bus128.in_decr  = decr;
    bus128.in_valid = 1'b1;
    @(posedge clk); #1;
    bus128.in_valid = 1'b0;
    bus128.in_decr  = ~decr;
    bus128.in_data  = ~d;
    lat   = 1;
    ka    = '0;
    ka[0] = ka128;
    while (!bus128.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat <= 11) ka[lat-1] = ka128;
    end
    res   = bus128.out_data;
    rdecr = bus128.out_decr;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus128.in_ready); end
    total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus128.out_valid); end
    total++; if (bus128.out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", bus128.out_data); end
    total++; if (bus128.out_decr !== 1'b0) begin bad++; $display("FAIL reset_out_decr: got %b want 0", bus128.out_decr); end
    total++; if (ka128 !== 4'd0) begin bad++; $display("FAIL reset_key_addr: got %0d want 0", ka128); end
    total++; if (busy128 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy128); end
    total++; if (st128 !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", st128, IDLE); end
  endtask

  task automatic test_enc128();
    bus128.out_ready = 1'b1;
    run128(PT, 1'b0);
    total++; if (lat != 13) begin bad++; $display("FAIL enc_latency: got %0d want 13", lat); end
    total++; if (res !== CT128) begin bad++; $display("FAIL enc_data: got %h want %h", res, CT128); end
    total++; if (rdecr !== 1'b0) begin bad++; $display("FAIL enc_out_decr: got %b want 0", rdecr); end
    for (int j = 0; j <= 10; j++) begin
      total++;
      if (ka[j] !== 4'(j)) begin bad++; $display("FAIL enc_key_addr[%0d]: got %0d want %0d", j, ka[j], j); end
    end
    @(posedge clk); #1;
    total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL enc_release_valid: got %b want 0", bus128.out_valid); end
    total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL enc_release_ready: got %b want 1", bus128.in_ready); end
  endtask

  task automatic test_dec128();
    bus128.out_ready = 1'b1;
    run128(CT128, 1'b1);
    total++; if (lat != 13) begin bad++; $display("FAIL dec_latency: got %0d want 13", lat); end
    total++; if (res !== PT) begin bad++; $display("FAIL dec_data: got %h want %h", res, PT); end
    total++; if (rdecr !== 1'b1) begin bad++; $display("FAIL dec_out_decr: got %b want 1", rdecr); end
    for (int j = 0; j <= 10; j++) begin
      total++;
      if (ka[j] !== 4'(10 - j)) begin bad++; $display("FAIL dec_key_addr[%0d]: got %0d want %0d", j, ka[j], 10 - j); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus128.out_ready = 1'b0;
    run128(PT, 1'b0);
    total++; if (res !== CT128) begin bad++; $display("FAIL bp_first_data: got %h want %h", res, CT128); end
    bus128.in_data  = CT128;
    bus128.in_decr  = 1'b1;
    bus128.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (bus128.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus128.out_valid); end
      total++; if (bus128.out_data !== CT128) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h want %h", i, bus128.out_data, CT128); end
      total++; if (bus128.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus128.in_ready); end
    end
    bus128.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop_valid: got %b want 0", bus128.out_valid); end
    total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready: got %b want 1", bus128.in_ready); end
    @(posedge clk); #1;
    bus128.in_valid = 1'b0;
    total++; if (st128 !== PRIME) begin bad++; $display("FAIL bp_second_accept: got state %0d want %0d", st128, PRIME); end
    lat = 1;
    while (!bus128.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat != 13) begin bad++; $display("FAIL bp_second_latency: got %0d want 13", lat); end
    total++; if (bus128.out_data !== PT) begin bad++; $display("FAIL bp_second_data: got %h want %h", bus128.out_data, PT); end
    total++; if (bus128.out_decr !== 1'b1) begin bad++; $display("FAIL bp_second_decr: got %b want 1", bus128.out_decr); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    bus128.out_ready = 1'b1;
    bus128.in_data   = PT;
    bus128.in_decr   = 1'b0;
    bus128.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus128.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (st128 !== ROUND) begin bad++; $display("FAIL rst_mid_in_round: got state %0d want %0d", st128, ROUND); end
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", bus128.out_valid); end
    total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", bus128.in_ready); end
    total++; if (ka128 !== 4'd0) begin bad++; $display("FAIL rst_mid_key_addr: got %0d want 0", ka128); end
    total++; if (busy128 !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy128); end
    reset = 1'b1;
    seen  = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (bus128.out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_output: got %0d valid cycles want 0", seen); end
    run128(CT128, 1'b1);
    total++; if (res !== PT) begin bad++; $display("FAIL rst_mid_next_data: got %h want %h", res, PT); end
    total++; if (lat != 13) begin bad++; $display("FAIL rst_mid_next_latency: got %0d want 13", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_aes192();
    int l;
    bus192.in_data  = PT;
    bus192.in_decr  = 1'b0;
    bus192.in_valid = 1'b1;
    @(posedge clk); #1;
    bus192.in_valid = 1'b0;
    l = 1;
    while (!bus192.out_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    total++; if (l != 15) begin bad++; $display("FAIL aes192_latency: got %0d want 15", l); end
    total++; if (bus192.out_data !== CT192) begin bad++; $display("FAIL aes192_enc: got %h want %h", bus192.out_data, CT192); end
    @(posedge clk); #1;
  endtask

  task automatic test_aes256();
    int l;
    for (int pass = 0; pass < 2; pass++) begin
      bus256.in_data  = (pass == 0) ? PT : CT256;
      bus256.in_decr  = (pass == 1);
      bus256.in_valid = 1'b1;
      @(posedge clk); #1;
      bus256.in_valid = 1'b0;
      l = 1;
      while (!bus256.out_valid && l < 40) begin
        @(posedge clk); #1;
        l++;
      end
      total++; if (l != 17) begin bad++; $display("FAIL aes256_latency[%0d]: got %0d want 17", pass, l); end
      total++;
      if (bus256.out_data !== ((pass == 0) ? CT256 : PT)) begin
        bad++; $display("FAIL aes256_data[%0d]: got %h want %h", pass, bus256.out_data, (pass == 0) ? CT256 : PT);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef AES_ITER_CORE_ABORT_EN
  task automatic test_abort();
    int seen;
    bus128.out_ready = 1'b1;
    bus128.in_data   = PT;
    bus128.in_decr   = 1'b0;
    bus128.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus128.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (st128 !== IDLE) begin bad++; $display("FAIL abort_round_state: got %0d want %0d", st128, IDLE); end
    total++; if (bus128.in_ready !== 1'b1) begin bad++; $display("FAIL abort_round_ready: got %b want 1", bus128.in_ready); end
    total++; if (ka128 !== 4'd0) begin bad++; $display("FAIL abort_round_key_addr: got %0d want 0", ka128); end
    seen = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (bus128.out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_round_no_output: got %0d want 0", seen); end
    run128(PT, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (st128 !== IDLE) begin bad++; $display("FAIL abort_done_state: got %0d want %0d", st128, IDLE); end
    total++; if (bus128.out_valid !== 1'b0) begin bad++; $display("FAIL abort_done_valid: got %b want 0", bus128.out_valid); end
    run128(PT, 1'b0);
    total++; if (res !== CT128) begin bad++; $display("FAIL abort_next_data: got %h want %h", res, CT128); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rk_set_t s128, s192, s256;
    s128 = expand({KEY_ALL[255:128], 128'h0}, 4);
    s192 = expand({KEY_ALL[255:64], 64'h0}, 6);
    s256 = expand(KEY_ALL, 8);
    for (int r = 0; r < 16; r++) begin
      mem128[r] = s128[r];
      mem192[r] = s192[r];
      mem256[r] = s256[r];
    end
    reset            = 1'b0;
    bus128.in_valid  = 1'b0; bus128.in_data = '0; bus128.in_decr = 1'b0; bus128.out_ready = 1'b1;
    bus192.in_valid  = 1'b0; bus192.in_data = '0; bus192.in_decr = 1'b0; bus192.out_ready = 1'b1;
    bus256.in_valid  = 1'b0; bus256.in_data = '0; bus256.in_decr = 1'b0; bus256.out_ready = 1'b1;
`ifdef AES_ITER_CORE_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_enc128();
    test_dec128();
    test_backpressure();
    test_reset_mid();
    test_aes192();
    test_aes256();
`ifdef AES_ITER_CORE_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
